// File: rtl/imem_pkg.sv
// Shared types and default geometry for the synchronous instruction memory.
package imem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam int IMEM_ADDR_W = 6;
    localparam int IMEM_DATA_W = 32;

endpackage

// File: rtl/imem_ram.sv
// Word-organised storage: one byte-enabled write port, one registered read-first read port.
module imem_ram #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int NBE    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [NBE-1:0]    be,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // The array itself is never reset; the clear engine in the top zeroes it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NBE; i++) begin
            if (we && be[i]) begin
                mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Only the output register is reset, so rd_data starts at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_sync.sv
// Synchronous instruction memory: registered read port, byte-enabled load port
// and a clear engine that zeroes the array after reset or on a clr pulse.
module imem_sync
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W,
    parameter int NBE    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    output logic              busy,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [NBE-1:0]    ld_be,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_drop
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] PTR_END = (ADDR_W + 1)'(DEPTH);

    state_t            state, state_nxt;
    logic [ADDR_W:0]   ptr, ptr_nxt, ptr_inc;
    logic              ld_ok;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [NBE-1:0]    ram_be;
    logic [DATA_W-1:0] ram_wdata;

    assign busy     = (state == ST_CLEAR);
    assign rd_ready = ~busy;
    assign ptr_inc  = ptr + {{ADDR_W{1'b0}}, 1'b1};
    // A clr in the same cycle outranks a load, which is then reported as dropped.
    assign ld_ok    = ld_we & ~busy & ~clr;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            ST_CLEAR: begin
                if (clr) begin
                    ptr_nxt = '0;
                end else if (ptr_inc == PTR_END) begin
                    state_nxt = ST_IDLE;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = ptr_inc;
                end
            end
            ST_IDLE: begin
                if (clr) begin
                    state_nxt = ST_CLEAR;
                    ptr_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_CLEAR;
                ptr_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        ram_we    = ld_ok;
        ram_addr  = ld_addr;
        ram_be    = ld_be;
        ram_wdata = ld_data;
        if (busy) begin
            ram_we    = 1'b1;
            ram_addr  = ptr[ADDR_W-1:0];
            ram_be    = '1;
            ram_wdata = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_CLEAR;
            ptr      <= '0;
            rd_valid <= 1'b0;
            ld_drop  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            rd_valid <= rd_req & ~busy;
            ld_drop  <= ld_we & (busy | clr);
        end
    end

    imem_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .NBE    (NBE)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .waddr (ram_addr),
        .be    (ram_be),
        .wdata (ram_wdata),
        .re    (rd_req & ~busy),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_imem_sync.sv
// Randomised and directed bench for imem_sync against a cycle-level behavioural model.
module tb_imem_sync;

    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          clr;
    logic          busy;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [NB-1:0] ld_be;
    logic [DW-1:0] ld_data;
    logic          ld_drop;

    imem_sync #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .busy     (busy),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .ld_we    (ld_we),
        .ld_addr  (ld_addr),
        .ld_be    (ld_be),
        .ld_data  (ld_data),
        .ld_drop  (ld_drop)
    );

    always #5 clk = ~clk;

    // Reference model: word array plus "cycles of clearing left".
    logic [DW-1:0] m_mem [DEPTH];
    int            m_clr_left;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_drop;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_clr_left = DEPTH;
        m_valid    = 1'b0;
        m_data     = '0;
        m_drop     = 1'b0;
    endtask

    task automatic check_outputs();
        chk("busy",     {31'b0, busy},     {31'b0, m_clr_left > 0});
        chk("rd_ready", {31'b0, rd_ready}, {31'b0, m_clr_left == 0});
        chk("rd_valid", {31'b0, rd_valid}, {31'b0, m_valid});
        chk("rd_data",  rd_data,           m_data);
        chk("ld_drop",  {31'b0, ld_drop},  {31'b0, m_drop});
    endtask

    // One clock: inputs are already stable; update the model from them, then compare.
    task automatic step();
        logic m_busy;
        @(posedge clk);
        #1;
        if (reset) begin
            model_reset();
        end else begin
            m_busy  = (m_clr_left > 0);
            m_valid = rd_req && !m_busy;
            if (m_valid) m_data = m_mem[rd_addr];
            m_drop = ld_we && (m_busy || clr);
            if (ld_we && !m_busy && !clr) begin
                for (int b = 0; b < NB; b++)
                    if (ld_be[b]) m_mem[ld_addr][8*b +: 8] = ld_data[8*b +: 8];
            end
            if (clr) begin
                m_clr_left = DEPTH;
                for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            end else if (m_busy) begin
                m_clr_left--;
            end
        end
        check_outputs();
    endtask

    task automatic idle_inputs();
        clr = 0; rd_req = 0; rd_addr = '0; ld_we = 0; ld_addr = '0; ld_be = '0; ld_data = '0;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [NB-1:0] be, input logic [DW-1:0] d);
        idle_inputs();
        ld_we = 1; ld_addr = a; ld_be = be; ld_data = d;
        step();
        idle_inputs();
    endtask

    task automatic read(input logic [AW-1:0] a);
        idle_inputs();
        rd_req = 1; rd_addr = a;
        step();
        idle_inputs();
    endtask

    task automatic drain_clear();
        for (int i = 0; i < 2 * DEPTH && m_clr_left > 0; i++) step();
    endtask

    int cnt;

    initial begin
        reset = 1'b1;
        idle_inputs();
        model_reset();
        #3;
        check_outputs();
        step();

        // Reset release: busy for exactly DEPTH cycles while a read is held.
        reset  = 1'b0;
        rd_req = 1; rd_addr = 6'h3F;
        cnt = busy ? 1 : 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            step();
            if (busy) cnt++;
        end
        chk("busy_len_reset", cnt, DEPTH);
        read(6'h3F);
        chk("clear_word_3f", rd_data, 32'h0);

        // Byte-enabled load and read-back.
        load(6'd0, 4'hF, 32'h20020005);
        load(6'd0, 4'h1, 32'h000000AB);
        read(6'd0);
        chk("byte_merge", rd_data, 32'h200200AB);
        load(6'd0, 4'h0, 32'hFFFFFFFF);
        read(6'd0);

        // Same-cycle read and load at one address: read-first.
        load(6'd5, 4'hF, 32'h11111111);
        idle_inputs();
        rd_req = 1; rd_addr = 6'd5;
        ld_we = 1; ld_addr = 6'd5; ld_be = 4'hF; ld_data = 32'h22222222;
        step();
        chk("collide_old", rd_data, 32'h11111111);
        read(6'd5);
        chk("collide_new", rd_data, 32'h22222222);

        // Clear, restart 10 cycles later, loads attempted while busy.
        load(6'd9, 4'hF, 32'hDEADBEEF);
        idle_inputs(); clr = 1; step(); idle_inputs();
        for (int i = 0; i < 9; i++) step();
        clr = 1; step(); clr = 0;
        cnt = busy ? 1 : 0;
        ld_we = 1; ld_addr = 6'd9; ld_be = 4'hF; ld_data = 32'h12345678;
        step(); idle_inputs();
        if (busy) cnt++;
        chk("drop_pulse", {31'b0, ld_drop}, 32'd1);
        for (int i = 0; i < DEPTH + 4; i++) begin
            step();
            if (busy) cnt++;
        end
        chk("busy_len_restart", cnt, DEPTH);

        // Streaming fetch of the whole array: one word per cycle, no gaps.
        cnt = 0;
        for (int i = 0; i < DEPTH; i++) begin
            rd_req = 1; rd_addr = AW'(i);
            step();
            if (rd_valid) cnt++;
        end
        idle_inputs(); step();
        chk("stream_valid_cnt", cnt, DEPTH);

        // Clear plus load in the same idle cycle: clear wins.
        idle_inputs();
        clr = 1; ld_we = 1; ld_addr = 6'd3; ld_be = 4'hF; ld_data = 32'hA5A5A5A5;
        step(); idle_inputs();
        for (int i = 0; i < 20; i++) step();

        // Reset asserted asynchronously mid-clear.
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("async_busy", {31'b0, busy}, 32'd1);
        chk("async_valid", {31'b0, rd_valid}, 32'd0);
        step();
        reset = 1'b0;
        cnt = busy ? 1 : 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            step();
            if (busy) cnt++;
        end
        chk("busy_len_rst_mid", cnt, DEPTH);

        // Random traffic with occasional clears.
        for (int i = 0; i < 3000; i++) begin
            clr     = ($urandom_range(0, 99) == 0);
            rd_req  = $urandom_range(0, 1);
            rd_addr = AW'($urandom);
            ld_we   = $urandom_range(0, 1);
            ld_addr = AW'($urandom_range(0, 7));
            ld_be   = NB'($urandom);
            ld_data = $urandom;
            step();
        end
        idle_inputs();
        drain_clear();

        // Final sweep of the model-tracked contents.
        for (int i = 0; i < DEPTH; i++) read(AW'(i));
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imem_sync.md
# imem_sync

Parametrised synchronous instruction memory for the MIPS cores, succeeding the combinational 64-word instruction ROM. It adds a registered read port with request/valid handshake, a byte-enabled load port so benches and boot logic write programs at run time, and a hardware clear engine that zeroes the whole array after reset or on demand. This guarantees every test image starts from a zeroed memory. It sits between the fetch stage and the test/boot loader.

## Interface

Parameters:
- ADDR_W, 6, word-address width; DEPTH = 2**ADDR_W words
- DATA_W, 32, word width; must be a multiple of 8
- NBE, DATA_W/8, number of byte lanes (derived; do not override)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- clr  in  1  one-cycle pulse that starts a clear of the whole array
- busy  out  1  high while the clear engine is running
- rd_req  in  1  read request, sampled on the clock edge
- rd_addr  in  ADDR_W  word address of the read
- rd_ready  out  1  read is accepted this cycle; equals !busy
- rd_valid  out  1  rd_data holds the word for the read accepted last cycle
- rd_data  out  DATA_W  read data
- ld_we  in  1  load write strobe
- ld_addr  in  ADDR_W  load word address
- ld_be  in  NBE  load byte enables; bit i covers bits 8i+7:8i
- ld_data  in  DATA_W  load write data
- ld_drop  out  1  one-cycle pulse: the load write in the previous cycle was discarded

## Operation

- Two states: CLEAR and IDLE.
- **Reset state:** CLEAR with clear pointer 0, busy=1, rd_valid=0, rd_data=0, ld_drop=0.
- **CLEAR:**
  - Each cycle, writes zero to RAM[ptr], then increments ptr.
  - When ptr = DEPTH-1 has been written, the next state is IDLE and busy drops.
  - A full clear takes exactly DEPTH cycles.
- **IDLE:** a clr pulse moves the block to CLEAR with ptr=0.
- **Clear restart:** a clr during CLEAR restarts ptr at 0, so the clear again takes DEPTH cycles from that edge.
- **Reads:**
  - A read is accepted when rd_req=1 and busy=0.
  - On the next edge, rd_valid=1 and rd_data=RAM[rd_addr].
  - With no accepted read, rd_valid=0 and rd_data holds its last value.
  - A rd_req during busy is ignored; it is not queued.
- **Loads:**
  - A load is performed when ld_we=1 and busy=0.
  - Only the bytes with ld_be set are written; the other bytes keep their value.
  - ld_be=0 is a legal no-op.
- **Dropped loads:** a ld_we with busy=1 is discarded and ld_drop=1 on the next cycle. The loader must retry after busy falls.
- **Read and load together:** a read and a load may occur in the same cycle. At the same address the read returns the old word (read-first).
- **Priority:** reset > clear engine > load write. A clr and a ld_we in the same IDLE cycle: the clear wins, the load is dropped, and ld_drop pulses.
- **Address range:** there are no out-of-range addresses, because DEPTH = 2**ADDR_W. The clear pointer is ADDR_W+1 bits wide internally so the terminal count does not alias to 0.

## Timing

- Read latency: 1 cycle, accept edge to rd_valid. Back-to-back reads give one word per cycle.
- Load write: visible to a read accepted on the following cycle.
- busy: registered; rises on the edge after clr and immediately on reset assertion.
- Reset mid-operation: asserting reset aborts any clear, read or load in progress. The array contents are not guaranteed; the clear that follows reset release zeroes them.
- rd_ready: combinational from busy only.

## Structure

- Package imem_pkg holds:
  - state enum {ST_CLEAR, ST_IDLE}
  - default constants IMEM_ADDR_W=6 and IMEM_DATA_W=32
- Sub-module imem_ram holds the storage:
  - one synchronous write port with byte enables
  - one synchronous read port with read-first behaviour
  - no reset on the array
- The top level muxes the write port between the clear engine and the load port. It also holds the state register, the clear pointer and the ld_drop flop.

## Test plan

Default parameters (ADDR_W=6, DATA_W=32).

- **Reset and clear:** release reset, then hold rd_req -> busy=1 for exactly 64 cycles and rd_ready=0 throughout. After busy falls, a read of addr 0x3F returns rd_valid=1 with rd_data=0x00000000 one cycle later.
- **Load and read-back:** load 0x20020005 at addr 0 with ld_be=4'hF, then load 0xAB at addr 0 with ld_be=4'h1 -> a read of addr 0 returns 0x200200AB.
- **Same-cycle collision:** RAM[5]=0x11111111; in one cycle, read addr 5 and load 0x22222222 to addr 5 -> rd_data=0x11111111. A read of addr 5 in the next cycle returns 0x22222222.
- **Clear mid-run:**
  - Pulse clr after loads, then pulse clr again 10 cycles later -> busy stays high for 64 cycles after the second pulse; all words then read 0.
  - A ld_we during busy -> ld_drop=1 one cycle later, and the word is unchanged.
- **Reset mid-clear:** assert reset 20 cycles into a clear -> rd_valid=0 and busy=1 immediately. After release, busy stays high for 64 cycles.
- **Streaming fetch:** issue reads of addrs 0..63 on consecutive cycles -> rd_valid is high for 64 consecutive cycles, with the data in address order and no gaps.
